// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit.
// Multiplication is an iterative shift-add and division is restoring division.
// Both work on operand magnitudes, one bit per cycle, for XLEN cycles.
// Divide-by-zero and signed overflow are resolved in the accept cycle and skip
// the iteration phase entirely.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nxt;

  // Latched operation context.
  logic [2:0]      op_q;
  logic            neg_q;   // final sign correction for the selected result
  logic [XLEN-1:0] d_q;     // |b|: multiplicand or divisor
  logic [XLEN-1:0] hi_q;    // product high half / partial remainder
  logic [XLEN-1:0] lo_q;    // multiplier bits / dividend bits becoming quotient
  logic [CW-1:0]   cnt_q;

  // ---------------------------------------------------------------------------
  // Accept-cycle decode (operates on the live inputs).
  // ---------------------------------------------------------------------------
  logic            sign_a, sign_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special, accept, last_iter;
  logic [XLEN-1:0] special_res;
  logic            neg_in;

  // Decode operand signedness, magnitudes and the divide special cases.
  always_comb begin
    sign_a   = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV)  || (funct3 == OP_REM);
    sign_b   = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    neg_a    = sign_a && a[XLEN-1];
    neg_b    = sign_b && b[XLEN-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    // The remainder follows the dividend; every other result follows the sign product.
    neg_in   = (funct3 == OP_REM) ? neg_a : (neg_a ^ neg_b);
    div_zero = funct3[2] && (b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (a == MOST_NEG) && (b == '1);
    special  = div_zero || div_ovf;
    // funct3[1] selects REM/REMU among the divide ops.
    if (div_zero) special_res = funct3[1] ? a : '1;
    else          special_res = funct3[1] ? '0 : a;
    accept    = (state != CALC) && start && !kill;
    last_iter = (cnt_q == CW'(XLEN - 1));
  end

  // ---------------------------------------------------------------------------
  // One iteration step and the sign-corrected final result.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, hi_nxt, lo_nxt, div_val, res_div, res_mul, final_res;
  logic [2*XLEN-1:0] prod, prod_s;

  // Compute the next shift-add or restore step, then the result it would finish with.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so that later lines see the
    // values just computed; the clocked blocks below use '<=' exclusively.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, d_q});
    div_diff  = div_shift[XLEN-1:0] - d_q;
    if (op_q[2]) begin
      hi_nxt = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod      = {hi_nxt, lo_nxt};
    prod_s    = neg_q ? -prod : prod;
    res_mul   = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_val   = op_q[1] ? hi_nxt : lo_nxt;
    res_div   = neg_q ? -div_val : div_val;
    final_res = op_q[2] ? res_div : res_mul;
  end

  // ---------------------------------------------------------------------------
  // Control FSM.
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: kill always wins; DONE accepts a new start like IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (kill)       state_nxt = IDLE;
        else if (start) state_nxt = special ? DONE : CALC;
        else            state_nxt = IDLE;
      end
      CALC: begin
        if (kill)           state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
        else                state_nxt = CALC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------------
  // Datapath registers.
  // ---------------------------------------------------------------------------
  // Load operands on accept, iterate in CALC, register the result on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too; they are few and flops, not
    // a memory array, so a defined post-reset value costs nothing.
    if (!rst_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      d_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= funct3;
      neg_q <= neg_in;
      d_q   <= mag_b;
      hi_q  <= '0;
      lo_q  <= mag_a;
      cnt_q <= '0;
      if (special) result <= special_res;
    end else if (state == CALC && !kill) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) result <= final_res;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (XLEN=32).
// Expected results and done cycles are pushed to a scoreboard when each
// operation is issued, and a monitor pops and compares them on every done.
module tb_muldiv_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            kill = 1'b0;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            busy, done;
  logic [XLEN-1:0] result;

  typedef struct {
    logic [XLEN-1:0] res;
    longint          done_edge;
  } exp_t;

  exp_t            sb[$];
  int              total = 0;
  int              bad = 0;
  longint          edge_cnt = 0;
  logic [XLEN-1:0] last_res = '0;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model built on the simulator's 64-bit arithmetic.
  function automatic void model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output bit sp);
    logic [63:0] p;
    int sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    sp = 1'b0;
    p  = '0;
    r  = '0;
    case (f)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
      3'd1: begin p = longint'(sx) * longint'(sy); r = p[63:32]; end
      3'd2: begin p = longint'(sx) * longint'({32'b0, y}); r = p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
      3'd4, 3'd6: begin
        if (y == 0) begin
          sp = 1'b1; r = (f == 3'd4) ? 32'hFFFF_FFFF : x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          sp = 1'b1; r = (f == 3'd4) ? x : 32'h0;
        end else begin
          r = (f == 3'd4) ? 32'(sx / sy) : 32'(sx % sy);
        end
      end
      default: begin
        if (y == 0) begin
          sp = 1'b1; r = (f == 3'd5) ? 32'hFFFF_FFFF : x;
        end else begin
          r = (f == 3'd5) ? x / y : x % y;
        end
      end
    endcase
  endfunction

  // Drive one start pulse from a negedge; scrambles the inputs right after acceptance.
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input bit push, input bit with_kill,
                       input bit use_exp, input logic [31:0] exp_res);
    logic [31:0] r;
    bit sp;
    model(f, x, y, r, sp);
    if (use_exp) r = exp_res;
    if (push) sb.push_back('{res: r, done_edge: edge_cnt + (sp ? 1 : 33)});
    funct3 = f;
    a      = x;
    b      = y;
    start  = 1'b1;
    kill   = with_kill;
    @(posedge clk);
    #1;
    start  = 1'b0;
    kill   = 1'b0;
    a      = $urandom;
    b      = $urandom;
    funct3 = 3'($urandom);
    check("busy_after_accept", {63'b0, busy}, {63'b0, (!sp && !with_kill)});
  endtask

  // Wait (bounded) until every queued result has been observed, then realign to a negedge.
  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check("done_expected", {63'b0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("done_cycle", edge_cnt, e.done_edge);
        last_res = e.res;
      end
    end
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB}); // MUL
    vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE}); // MULHU
    vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD}); // DIV
    vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF}); // REM
    vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF}); // MULHSU
    vecs.push_back('{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF}); // DIVU /0
    vecs.push_back('{3'b111, 32'd5,          32'd0,         32'd5});         // REMU /0
    vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000}); // DIV ovf
    vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0});         // REM ovf
    vecs.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000}); // MULH
    vecs.push_back('{3'b100, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2}); // DIV 100/-7
    vecs.push_back('{3'b110, 32'd100,        32'hFFFF_FFF9, 32'd2});         // REM 100%-7

    // Reset state.
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_result", result, 64'd0);

    // Release reset and start on the very first rising edge afterwards.
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].x, vecs[i].y, 1'b1, 1'b0, 1'b1, vecs[i].r);
      wait_idle();
    end

    // Random operations, with forced divide special cases mixed in.
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f;
      logic [31:0] x, y;
      f = 3'($urandom);
      x = $urandom;
      y = $urandom;
      if (i % 6 == 0) y = '0;
      if (i % 6 == 3) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (i % 6 == 5) y = 32'($urandom_range(1, 15));
      issue(f, x, y, 1'b1, 1'b0, 1'b0, '0);
      wait_idle();
    end

    // Back-to-back: second start issued in the DONE cycle of the first.
    issue(3'b000, 32'd1234, 32'd5678, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b_first_done", {63'b0, done}, 64'd1);
    issue(3'b101, 32'd1000, 32'd7, 1'b1, 1'b0, 1'b1, 32'd142);
    wait_idle();

    // Kill at cycle 10 of a DIV: no done, result held, then a fresh op at cycle 12.
    issue(3'b100, 32'd99, 32'd3, 1'b0, 1'b0, 1'b0, '0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy", {63'b0, busy}, 64'd0);
    check("kill_done", {63'b0, done}, 64'd0);
    check("kill_result_held", result, {32'b0, last_res});
    @(negedge clk);
    issue(3'b110, 32'd100, 32'd7, 1'b1, 1'b0, 1'b1, 32'd2);
    wait_idle();

    // Kill together with start in IDLE: start is discarded.
    issue(3'b000, 32'd3, 32'd3, 1'b0, 1'b1, 1'b0, '0);
    repeat (40) @(negedge clk);
    check("killstart_result_held", result, {32'b0, last_res});

    // Reset asserted at cycle 5 of a MUL: outputs clear at once, no done afterwards.
    issue(3'b000, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_result", result, 64'd0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("postrst_result", result, 64'd0);
    issue(3'b000, 32'd9, 32'd9, 1'b1, 1'b0, 1'b1, 32'd81);
    wait_idle();

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
